// File: rtl/divider_ctrl.sv
// Programmable modulo-N counter / frequency divider controller.
// Owns the divisor and count registers. New divisors arrive over a valid/ready
// handshake and are applied only at a period boundary. Produces a terminal
// tick and a near-50% clock-enable waveform.
module divider_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             running,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             clk_out
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;

  logic             xfer;
  logic             terminal;
  logic [WIDTH-1:0] next_div;
  logic [WIDTH:0]   half_period;

  assign xfer     = cfg_valid & ~pend_valid_q;
  // div_q is never zero in RUN, but guard the subtraction anyway.
  assign terminal = (state_q == RUN) && (div_q != '0) && (count_q == div_q - ONE);

  // A transfer landing on the terminal cycle bypasses the pending register and
  // is applied at this same wrap, so pend_valid never becomes visible.
  assign next_div = pend_valid_q ? pend_div_q : (xfer ? cfg_div : div_q);

  // ceil(N/2) computed one bit wider so N = 2^WIDTH-1 does not overflow.
  assign half_period = ({1'b0, div_q} + {{WIDTH{1'b0}}, 1'b1}) >> 1;

  // Next-state: configuration load, counting, wrap and pending application.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    count_d      = count_q;
    pend_valid_d = pend_valid_q;
    pend_div_d   = pend_div_q;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (xfer && (cfg_div != '0)) begin
          div_d   = cfg_div;
          state_d = RUN;
        end
      end
      RUN: begin
        if (en && terminal) begin
          count_d      = '0;
          div_d        = next_div;
          pend_valid_d = 1'b0;
          if (next_div == '0) begin
            state_d = IDLE;
          end
        end else begin
          if (en) begin
            count_d = count_q + ONE;
          end
          if (xfer) begin
            pend_valid_d = 1'b1;
            pend_div_d   = cfg_div;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      count_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_div_q   <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      count_q      <= count_d;
      pend_valid_q <= pend_valid_d;
      pend_div_q   <= pend_div_d;
    end
  end

  assign running   = (state_q == RUN);
  assign count     = count_q;
  assign cfg_ready = ~pend_valid_q;
  assign tick      = running & en & terminal;
  assign clk_out   = running & ({1'b0, count_q} < half_period);

endmodule

// File: tb/tb_divider_ctrl.sv
// Self-checking bench for divider_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_divider_ctrl;

  logic       clk;
  logic       reset;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       running;
  logic [7:0] count;
  logic       tick;
  logic       clk_out;

  divider_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .running   (running),
    .count     (count),
    .tick      (tick),
    .clk_out   (clk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit m_ok   = 0;
  bit m_run  = 0;
  int m_div  = 0;
  int m_cnt  = 0;
  bit m_pend = 0;
  int m_pdiv = 0;

  // Outputs sampled mid-cycle by the last step
  logic       s_rdy, s_run, s_tk, s_co;
  logic [7:0] s_cnt;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Apply one cycle of inputs, compare against the model mid-cycle, advance.
  task automatic step(input logic r, input logic e, input logic v, input logic [7:0] d);
    bit accept;
    int nd;
    reset = r; en = e; cfg_valid = v; cfg_div = d;
    #4;
    s_rdy = cfg_ready; s_run = running; s_cnt = count; s_tk = tick; s_co = clk_out;
    if (m_ok) begin
      chk("m_ready",   32'(s_rdy), 32'(!m_pend));
      chk("m_running", 32'(s_run), 32'(m_run));
      chk("m_count",   32'(s_cnt), 32'(m_cnt));
      chk("m_tick",    32'(s_tk),  32'(m_run && e && (m_cnt == m_div - 1)));
      chk("m_clk_out", 32'(s_co),  32'(m_run && (m_cnt < (m_div + 1) / 2)));
    end
    if (r) begin
      m_ok = 1; m_run = 0; m_div = 0; m_cnt = 0; m_pend = 0; m_pdiv = 0;
    end else begin
      accept = v && !m_pend;
      if (!m_run) begin
        if (accept && d != 0) begin
          m_run = 1; m_div = int'(d); m_cnt = 0;
        end
      end else if (e) begin
        if (m_cnt + 1 == m_div) begin
          nd = m_pend ? m_pdiv : (accept ? int'(d) : m_div);
          m_pend = 0;
          m_div = nd;
          m_cnt = 0;
          if (nd == 0) m_run = 0;
        end else begin
          m_cnt = (m_cnt + 1) % m_div;
          if (accept) begin m_pend = 1; m_pdiv = int'(d); end
        end
      end else if (accept) begin
        m_pend = 1; m_pdiv = int'(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int tgt);
    for (int unsigned k = 0; k < 600 && m_cnt != tgt; k++) step(0, 1, 0, 0);
  endtask

  typedef struct {
    logic       en;
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       run;
    logic [7:0] cnt;
    logic       tk;
    logic       co;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // en v d     rdy run cnt tk co
    tbl[0]  = '{1, 1, 8'd4, 1, 0, 8'd0, 0, 0};
    tbl[1]  = '{1, 0, 8'd0, 1, 1, 8'd0, 0, 1};
    tbl[2]  = '{1, 0, 8'd0, 1, 1, 8'd1, 0, 1};
    tbl[3]  = '{1, 0, 8'd0, 1, 1, 8'd2, 0, 0};
    tbl[4]  = '{1, 0, 8'd0, 1, 1, 8'd3, 1, 0};
    tbl[5]  = '{1, 0, 8'd0, 1, 1, 8'd0, 0, 1};
    tbl[6]  = '{1, 1, 8'd3, 1, 1, 8'd1, 0, 1};
    tbl[7]  = '{1, 0, 8'd0, 0, 1, 8'd2, 0, 0};
    tbl[8]  = '{1, 0, 8'd0, 0, 1, 8'd3, 1, 0};
    tbl[9]  = '{1, 0, 8'd0, 1, 1, 8'd0, 0, 1};
    tbl[10] = '{1, 0, 8'd0, 1, 1, 8'd1, 0, 1};
    tbl[11] = '{1, 0, 8'd0, 1, 1, 8'd2, 1, 0};
    tbl[12] = '{1, 0, 8'd0, 1, 1, 8'd0, 0, 1};

    reset = 1; en = 0; cfg_valid = 0; cfg_div = '0;
    @(posedge clk); #1;
    step(1, 0, 0, 0);

    // Plan items 1 and 2: N=4 startup, then switch to N=3 mid-period.
    for (int unsigned i = 0; i < 13; i++) begin
      step(0, tbl[i].en, tbl[i].v, tbl[i].d);
      chk("tbl_ready",   32'(s_rdy), 32'(tbl[i].rdy));
      chk("tbl_running", 32'(s_run), 32'(tbl[i].run));
      chk("tbl_count",   32'(s_cnt), 32'(tbl[i].cnt));
      chk("tbl_tick",    32'(s_tk),  32'(tbl[i].tk));
      chk("tbl_clk_out", 32'(s_co),  32'(tbl[i].co));
    end

    // Plan 3: N=5, transfer of 2 on the terminal cycle.
    step(1, 0, 0, 0);
    step(0, 1, 1, 8'd5);
    run_to(4);
    step(0, 1, 1, 8'd2);
    chk("t3_term_cnt", 32'(s_cnt), 32'd4);
    chk("t3_term_tick", 32'(s_tk), 32'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      chk("t3_cnt", 32'(s_cnt), 32'(i % 2));
      chk("t3_ready", 32'(s_rdy), 32'd1);
    end

    // Plan 4: N=6, en low for 3 cycles at count 2.
    step(1, 0, 0, 0);
    step(0, 1, 1, 8'd6);
    run_to(2);
    for (int unsigned i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("t4_hold_cnt", 32'(s_cnt), 32'd2);
      chk("t4_hold_tick", 32'(s_tk), 32'd0);
      chk("t4_hold_co", 32'(s_co), 32'd1);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      chk("t4_resume_cnt", 32'(s_cnt), 32'(2 + i));
      chk("t4_resume_tick", 32'(s_tk), 32'(i == 3));
    end

    // Plan 5: N=3 stop request, then N=1.
    step(1, 0, 0, 0);
    step(0, 1, 1, 8'd3);
    step(0, 1, 1, 8'd0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("t5_last_tick", 32'(s_tk), 32'd1);
    step(0, 1, 0, 0);
    chk("t5_stop_run", 32'(s_run), 32'd0);
    chk("t5_stop_cnt", 32'(s_cnt), 32'd0);
    chk("t5_stop_co", 32'(s_co), 32'd0);
    step(0, 1, 1, 8'd0);
    step(0, 1, 0, 0);
    chk("t5_zero_idle", 32'(s_run), 32'd0);
    step(0, 1, 1, 8'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      chk("t5_n1_tick", 32'(s_tk), 32'd1);
      chk("t5_n1_co", 32'(s_co), 32'd1);
      chk("t5_n1_cnt", 32'(s_cnt), 32'd0);
    end

    // Plan 6: reset discards a pending update.
    step(1, 0, 0, 0);
    step(0, 1, 1, 8'd4);
    step(0, 1, 1, 8'd7);
    step(0, 1, 0, 0);
    chk("t6_pend_ready", 32'(s_rdy), 32'd0);
    step(1, 1, 0, 0);
    for (int unsigned i = 0; i < 10; i++) begin
      step(0, 1, 0, 0);
      chk("t6_ready", 32'(s_rdy), 32'd1);
      chk("t6_running", 32'(s_run), 32'd0);
      chk("t6_cnt", 32'(s_cnt), 32'd0);
      chk("t6_co", 32'(s_co), 32'd0);
    end

    // Randomized traffic against the model.
    for (int unsigned i = 0; i < 4000; i++) begin
      logic       r, e, v;
      logic [7:0] d;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 9) < 8);
      v = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 59) == 0) d = 8'($urandom_range(200, 255));
      else d = 8'($urandom_range(0, 9));
      step(r, e, v, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
